// File: rtl/hamming_scrubber.sv
// hamming_scrubber: walks a synchronous RAM of Hamming(7,4) codewords
// {d3,d2,d1,d0,p2,p1,p0} from address 0 to DEPTH-1. For each word it computes
// the syndrome, corrects any single-bit error and streams out the corrected
// data nibble. It also counts the words that needed correction.
// Optional feature macro: HAMMING_SCRUB_WRITEBACK_EN. When it is defined, a
// WRITE state stores the corrected codeword back into the RAM.
module hamming_scrubber #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [6:0]        mem_q,
  output logic              mem_wren,
  output logic [6:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        dout,
  output logic [2:0]        dout_syn,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3
`ifdef HAMMING_SCRUB_WRITEBACK_EN
    , S_WRITE = 3'd4
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        syn;
  logic              syn_nz;
  logic [3:0]        flip;
  logic [3:0]        data_fix;
  logic              last;
  logic              scrub_hit;

  assign last   = (addr == ADDR_W'(DEPTH - 1));
  assign syn_nz = |syn;

  // Syndrome of the word on mem_q. A nonzero value names the bit that is wrong.
  always_comb begin
    syn[2] = mem_q[2] ^ mem_q[6] ^ mem_q[5] ^ mem_q[4];
    syn[1] = mem_q[1] ^ mem_q[6] ^ mem_q[5] ^ mem_q[3];
    syn[0] = mem_q[0] ^ mem_q[6] ^ mem_q[4] ^ mem_q[3];
  end

  // Map the syndrome to a data-bit flip. Parity-bit errors leave the data unchanged.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    flip = 4'b0000;
    case (syn)
      3'b111:  flip = 4'b1000;
      3'b110:  flip = 4'b0100;
      3'b101:  flip = 4'b0010;
      3'b011:  flip = 4'b0001;
      default: flip = 4'b0000;
    endcase
  end

  assign data_fix = mem_q[6:3] ^ flip;

`ifdef HAMMING_SCRUB_WRITEBACK_EN
  assign scrub_hit = syn_nz;
`else
  assign scrub_hit = 1'b0;
`endif

  // Next-state logic. Abort overrides every transition, including leaving IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  state_nx = S_CHECK;
      S_CHECK: begin
`ifdef HAMMING_SCRUB_WRITEBACK_EN
        if (syn_nz)    state_nx = S_WRITE;
        else
`endif
        if (last)      state_nx = S_DONE;
        else           state_nx = S_READ;
      end
`ifdef HAMMING_SCRUB_WRITEBACK_EN
      S_WRITE: state_nx = last ? S_DONE : S_READ;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Scan address, result registers and the saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      dout       <= 4'h0;
      dout_syn   <= 3'b000;
      dout_valid <= 1'b0;
      err_count  <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              addr      <= '0;
              err_count <= '0;
            end
          end
          S_CHECK: begin
            dout       <= data_fix;
            dout_syn   <= syn;
            dout_valid <= 1'b1;
            if (syn_nz && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
            if (!scrub_hit && !last) addr <= addr + 1'b1;
          end
`ifdef HAMMING_SCRUB_WRITEBACK_EN
          S_WRITE: begin
            if (!last) addr <= addr + 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign mem_addr = addr;
  assign done     = (state == S_DONE);

`ifdef HAMMING_SCRUB_WRITEBACK_EN
  assign busy     = (state == S_READ) || (state == S_CHECK) || (state == S_WRITE);
  // dout still holds the corrected nibble during WRITE, so re-encoding it
  // produces the clean codeword without keeping a separate copy.
  assign mem_wren = (state == S_WRITE);
  assign mem_data = (state == S_WRITE)
                  ? {dout,
                     dout[3] ^ dout[2] ^ dout[1],
                     dout[3] ^ dout[2] ^ dout[0],
                     dout[3] ^ dout[1] ^ dout[0]}
                  : 7'b0000000;
`else
  assign busy     = (state == S_READ) || (state == S_CHECK);
  assign mem_wren = 1'b0;
  assign mem_data = 7'b0000000;
`endif

endmodule

// File: tb/tb_hamming_scrubber.sv
// tb_hamming_scrubber: directed bench for hamming_scrubber with a behavioural
// synchronous RAM. CNT_W is set to 3 so that the counter saturates at 7.
`timescale 1ns/1ps
module tb_hamming_scrubber;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 3;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
  localparam int SCRUB = 1;
`else
  localparam int SCRUB = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [6:0]        mem_q;
  logic              mem_wren;
  logic [6:0]        mem_data;
  logic              busy;
  logic              done;
  logic [3:0]        dout;
  logic [2:0]        dout_syn;
  logic              dout_valid;
  logic [CNT_W-1:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  hamming_scrubber #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mem_addr(mem_addr), .mem_q(mem_q), .mem_wren(mem_wren), .mem_data(mem_data),
    .busy(busy), .done(done), .dout(dout), .dout_syn(dout_syn),
    .dout_valid(dout_valid), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with a bench-side load port.
  logic [6:0]        ram [0:(1<<ADDR_W)-1];
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [6:0]        ld_data = '0;
  always @(posedge clk) begin
    if (ld_en)         ram[ld_addr]  <= ld_data;
    else if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  typedef struct {
    logic [6:0] word;
    logic [3:0] exp_d;
    logic [2:0] exp_syn;
    logic [6:0] fixed;
  } vec_t;

  vec_t       vecs [16];
  logic [6:0] clean_cw [16];
  logic [6:0] img [16];

  logic [3:0]        q_d [$];
  logic [2:0]        q_s [$];
  logic [ADDR_W-1:0] q_wa [$];
  logic [6:0]        q_wd [$];
  int                done_cyc;
  int                first_valid;
  int                n_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = img[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle 1 (the cycle the start edge opens).
  task automatic start_scan(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Records the results of one scan, counting cycles from cycle 1.
  task automatic collect(input int budget);
    int c;
    q_d.delete(); q_s.delete(); q_wa.delete(); q_wd.delete();
    done_cyc = 0; first_valid = 0;
    c = 1;
    while (c <= budget) begin
      if (dout_valid) begin
        if (first_valid == 0) first_valid = c;
        q_d.push_back(dout);
        q_s.push_back(dout_syn);
      end
      if (mem_wren) begin
        q_wa.push_back(mem_addr);
        q_wd.push_back(mem_data);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    n_valid = q_d.size();
    while (q_d.size() < 16) begin
      q_d.push_back(4'bxxxx);
      q_s.push_back(3'bxxx);
    end
  endtask

  initial begin
    int cnt;

    clean_cw = '{7'b0000000, 7'b0001011, 7'b0010101, 7'b0011110,
                 7'b0100110, 7'b0101101, 7'b0110011, 7'b0111000,
                 7'b1000111, 7'b1001100, 7'b1010010, 7'b1011001,
                 7'b1100001, 7'b1101010, 7'b1110100, 7'b1111111};

    // One vector per address: every syndrome value, on several data nibbles.
    vecs[0]  = '{7'b0000000, 4'h0, 3'b000, 7'b0000000};
    vecs[1]  = '{7'b0101100, 4'h5, 3'b001, 7'b0101101};
    vecs[2]  = '{7'b0101111, 4'h5, 3'b010, 7'b0101101};
    vecs[3]  = '{7'b1001000, 4'h9, 3'b100, 7'b1001100};
    vecs[4]  = '{7'b1011110, 4'h3, 3'b111, 7'b0011110};
    vecs[5]  = '{7'b1111001, 4'hB, 3'b110, 7'b1011001};
    vecs[6]  = '{7'b1110001, 4'hC, 3'b101, 7'b1100001};
    vecs[7]  = '{7'b0111011, 4'h6, 3'b011, 7'b0110011};
    vecs[8]  = '{7'b1111111, 4'hF, 3'b000, 7'b1111111};
    vecs[9]  = '{7'b1110111, 4'hF, 3'b011, 7'b1111111};
    vecs[10] = '{7'b1010010, 4'hA, 3'b000, 7'b1010010};
    vecs[11] = '{7'b0000001, 4'h0, 3'b001, 7'b0000000};
    vecs[12] = '{7'b1000000, 4'h0, 3'b111, 7'b0000000};
    vecs[13] = '{7'b1101010, 4'hD, 3'b000, 7'b1101010};
    vecs[14] = '{7'b1110000, 4'hE, 3'b100, 7'b1110100};
    vecs[15] = '{7'b0011000, 4'h7, 3'b110, 7'b0111000};

    // Reset values.
    #2 reset = 1'b0;
    #1;
    check("reset_outputs",
          {mem_addr, mem_wren, mem_data, busy, done, dout, dout_syn, dout_valid, err_count},
          '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Clean RAM: nibbles 0..15, no errors.
    for (int i = 0; i < 16; i++) img[i] = clean_cw[i];
    load_img();
    start_scan(1'b0);
    collect(200);
    check("clean_nvalid", n_valid, 16);
    check("clean_first_valid_cycle", first_valid, 3);
    check("clean_done_cycle", done_cyc, 33);
    check("clean_err_count", err_count, 0);
    check("clean_nwrites", q_wa.size(), 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clean_dout[%0d]", i), q_d[i], i);
      check($sformatf("clean_syn[%0d]", i), q_s[i], 0);
    end
    @(negedge clk);
    check("clean_idle_after_done", {busy, done}, 2'b00);

    // Word 11 with d2 flipped.
    img[11] = 7'b1111001;
    load_img();
    start_scan(1'b0);
    collect(200);
    check("w11_dout", q_d[11], 4'hB);
    check("w11_syn", q_s[11], 3'b110);
    check("w11_err_count", err_count, 1);
    check("w11_done_cycle", done_cyc, 33 + SCRUB);
    check("w11_nwrites", q_wa.size(), SCRUB);
    for (int i = 0; i < q_wa.size(); i++) begin
      check("w11_wr_addr", q_wa[i], 11);
      check("w11_wr_data", q_wd[i], 7'b1011001);
    end
    check("w11_ram_after", ram[11], SCRUB ? 7'b1011001 : 7'b1111001);

    // Table of vectors: every syndrome, counter saturating at 7.
    for (int i = 0; i < 16; i++) img[i] = vecs[i].word;
    load_img();
    start_scan(1'b0);
    collect(200);
    check("tab_nvalid", n_valid, 16);
    check("tab_err_count_sat", err_count, 7);
    check("tab_done_cycle", done_cyc, 33 + 12 * SCRUB);
    check("tab_nwrites", q_wa.size(), 12 * SCRUB);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tab_dout[%0d]", i), q_d[i], vecs[i].exp_d);
      check($sformatf("tab_syn[%0d]", i), q_s[i], vecs[i].exp_syn);
      check($sformatf("tab_ram[%0d]", i), ram[i], SCRUB ? vecs[i].fixed : vecs[i].word);
    end

    // Every word with p0 flipped.
    for (int i = 0; i < 16; i++) img[i] = clean_cw[i] ^ 7'b0000001;
    load_img();
    start_scan(1'b0);
    collect(200);
    check("p0_err_count_sat", err_count, 7);
    check("p0_done_cycle", done_cyc, 33 + 16 * SCRUB);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("p0_dout[%0d]", i), q_d[i], i);
      check($sformatf("p0_syn[%0d]", i), q_s[i], 3'b001);
    end

    // Abort during CHECK of address 5 (p0-flipped RAM again).
    load_img();
    start_scan(1'b0);
    repeat ((2 + SCRUB) * 5 + 1) @(negedge clk);
    check("abort_at_addr", mem_addr, 5);
    check("abort_busy_before", {busy, mem_wren}, 2'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_after", {busy, mem_wren, done}, 3'b000);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_done", cnt, 0);
    start_scan(1'b0);
    check("restart_err_cleared", err_count, 0);
    check("restart_addr0", mem_addr, 0);
    collect(200);
    check("restart_first_valid_cycle", first_valid, 3);
    check("restart_dout0", q_d[0], 4'h0);
    check("restart_done_cycle", done_cyc, 33 + 11 * SCRUB);

    // Start held high for a whole scan.
    for (int i = 0; i < 16; i++) img[i] = clean_cw[i];
    load_img();
    start_scan(1'b1);
    collect(200);
    check("hold_nvalid", n_valid, 16);
    check("hold_done_cycle", done_cyc, 33);
    for (int i = 0; i < 16; i++) check($sformatf("hold_dout[%0d]", i), q_d[i], i);
    @(negedge clk);
    check("hold_idle_gap", busy, 1'b0);
    @(negedge clk);
    check("hold_rescan_busy", busy, 1'b1);
    check("hold_rescan_addr", mem_addr, 0);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Reset in the middle of a scan, at address 7.
    start_scan(1'b0);
    repeat (14) @(negedge clk);
    check("midreset_addr_before", mem_addr, 7);
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs",
          {mem_addr, mem_wren, mem_data, busy, done, dout, dout_syn, dout_valid, err_count},
          '0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_wren || busy) cnt++;
    end
    check("midreset_stays_idle", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
